pwm_fade_controller: RTL and testbench

Sequences the PWM peripheral's duty-cycle input. It ramps the applied duty value toward an SPI-programmed target at a programmable rate and step size, giving soft start, soft stop and fades instead of abrupt jumps. It sits between the SPI register block's duty register and the PWM peripheral's duty input, in the system clock domain.

---
 rtl/pwm_fade_controller_if.sv | 20 ++
 rtl/pwm_fade_controller.sv | 128 ++++++++++++
 tb/tb_pwm_fade_controller.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_fade_controller_if.sv
// rtl/pwm_fade_controller_if.sv - duty request / applied duty bundle for the PWM fade controller
interface pwm_fade_controller_if;
    logic [7:0] target_duty;
    logic       fade_en;
    logic [7:0] step_div;
    logic [3:0] step_size;
    logic [7:0] duty_out;
    logic       busy;
    logic       done;

    modport master (
        output target_duty, fade_en, step_div, step_size,
        input  duty_out, busy, done
    );

    modport slave (
        input  target_duty, fade_en, step_div, step_size,
        output duty_out, busy, done
    );
endinterface

// File: rtl/pwm_fade_controller.sv
// rtl/pwm_fade_controller.sv - ramps the applied PWM duty toward a programmed target
module pwm_fade_controller #(
    parameter int PRESCALE = 100,
    parameter int PRE_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pwm_fade_controller_if.slave ctrl
);
    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

    state_t            r_state, w_state_nxt;
    logic [PRE_W-1:0]  r_pre, w_pre_nxt;
    logic [7:0]        r_tick, w_tick_nxt;
    logic [7:0]        r_duty, w_duty_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;

    logic [7:0]        w_n;
    logic [8:0]        w_s;
    logic [8:0]        w_tgt9;
    logic [8:0]        w_sum;
    logic [8:0]        w_diff;
    logic [7:0]        w_up_val;
    logic [7:0]        w_dn_val;
    logic [7:0]        w_step_val;
    logic              w_base_tick;
    logic              w_step;

    assign w_n         = (ctrl.step_div == 8'd0) ? 8'd1 : ctrl.step_div;
    assign w_s         = {5'd0, (ctrl.step_size == 4'd0) ? 4'd1 : ctrl.step_size};
    assign w_tgt9      = {1'b0, ctrl.target_duty};
    assign w_sum       = {1'b0, r_duty} + w_s;
    assign w_diff      = {1'b0, r_duty} - w_s;
    assign w_base_tick = (r_pre == PRE_W'(PRESCALE - 1));
    // >= keeps the ramp moving if step_div is lowered below the current tick count
    assign w_step      = w_base_tick && (r_tick >= (w_n - 8'd1));

    // A 9-bit borrow shows up in bit 8, so an underflow clamps to target too
    assign w_up_val    = (w_sum > w_tgt9) ? ctrl.target_duty : w_sum[7:0];
    assign w_dn_val    = (w_diff[8] || (w_diff < w_tgt9)) ? ctrl.target_duty : w_diff[7:0];

    always_comb begin
        w_step_val = r_duty;
        if (ctrl.target_duty > r_duty) begin
            w_step_val = w_up_val;
        end else if (ctrl.target_duty < r_duty) begin
            w_step_val = w_dn_val;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_tick_nxt  = r_tick;
        w_duty_nxt  = r_duty;
        w_done_nxt  = 1'b0;

        if (!ctrl.fade_en) begin
            w_state_nxt = IDLE;
            w_duty_nxt  = ctrl.target_duty;
            w_pre_nxt   = '0;
            w_tick_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_pre_nxt  = '0;
                    w_tick_nxt = '0;
                    if (ctrl.target_duty > r_duty) begin
                        w_state_nxt = RAMP_UP;
                    end else if (ctrl.target_duty < r_duty) begin
                        w_state_nxt = RAMP_DOWN;
                    end
                end
                default: begin
                    if (w_step) begin
                        w_pre_nxt  = '0;
                        w_tick_nxt = '0;
                        w_duty_nxt = w_step_val;
                        if (w_step_val == ctrl.target_duty) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end else if (ctrl.target_duty > w_step_val) begin
                            w_state_nxt = RAMP_UP;
                        end else begin
                            w_state_nxt = RAMP_DOWN;
                        end
                    end else if (ctrl.target_duty == r_duty) begin
                        // target moved onto the current duty between steps
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                        w_pre_nxt   = '0;
                        w_tick_nxt  = '0;
                    end else if (w_base_tick) begin
                        w_pre_nxt  = '0;
                        w_tick_nxt = r_tick + 8'd1;
                    end else begin
                        w_pre_nxt  = r_pre + PRE_W'(1);
                    end
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pre   <= '0;
            r_tick  <= '0;
            r_duty  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pre   <= w_pre_nxt;
            r_tick  <= w_tick_nxt;
            r_duty  <= w_duty_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign ctrl.duty_out = r_duty;
    assign ctrl.busy     = r_busy;
    assign ctrl.done     = r_done;
endmodule

// File: tb/tb_pwm_fade_controller.sv
// tb/tb_pwm_fade_controller.sv - scoreboard bench for pwm_fade_controller
module tb_pwm_fade_controller;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pwm_fade_controller_if ctrl();

    pwm_fade_controller #(.PRESCALE(P), .PRE_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (ctrl)
    );

    typedef struct {
        int         cyc;
        logic [7:0] duty;
        logic       busy;
        logic       done;
    } ev_t;

    ev_t q[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    // model's view of the outputs after the last predicted edge
    int  m_duty = 0;
    bit  m_busy = 1'b0;
    bit  m_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] l_duty = 8'h00;
    logic       l_busy = 1'b0;
    logic       l_done = 1'b0;
    ev_t        mon_e;

    always @(negedge clk) begin
        if (ctrl.duty_out !== l_duty || ctrl.busy !== l_busy || ctrl.done !== l_done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d got duty=%h busy=%b done=%b, required no change",
                         cyc, ctrl.duty_out, ctrl.busy, ctrl.done);
            end else begin
                mon_e = q.pop_front();
                if (mon_e.cyc != cyc || mon_e.duty !== ctrl.duty_out ||
                    mon_e.busy !== ctrl.busy || mon_e.done !== ctrl.done) begin
                    errors++;
                    $display("FAIL output_event got cyc=%0d duty=%h busy=%b done=%b required cyc=%0d duty=%h busy=%b done=%b",
                             cyc, ctrl.duty_out, ctrl.busy, ctrl.done,
                             mon_e.cyc, mon_e.duty, mon_e.busy, mon_e.done);
                end
            end
            l_duty = ctrl.duty_out;
            l_busy = ctrl.busy;
            l_done = ctrl.done;
        end
    end

    task automatic expect_at(input int c, input int d, input bit b, input bit dn);
        ev_t e;
        if (d != m_duty || b != m_busy || dn != m_done) begin
            e.cyc  = c;
            e.duty = 8'(d);
            e.busy = b;
            e.done = dn;
            q.push_back(e);
            m_duty = d;
            m_busy = b;
            m_done = dn;
        end
    endtask

    task automatic check_val(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, got, req);
        end
    endtask

    // Behavioural ramp: edges at fixed N*P intervals move duty by S toward
    // whatever target is present; meeting the target anywhere ends the ramp.
    task automatic model_ramp(input int t0, input int tA, input int tchg, input int tB,
                              input int tabort, input bit arst, input int n, input int s,
                              output int t_stop, output bit aborted);
        int d;
        int tgt;
        d       = m_duty;
        aborted = 1'b0;
        t_stop  = t0 - 1;
        if (d == tA) return;
        expect_at(t0, d, 1'b1, 1'b0);
        for (int c = t0 + 1; c < t0 + 20000; c++) begin
            tgt = (tchg > 0 && c >= tchg) ? tB : tA;
            if (tabort > 0 && c >= tabort) begin
                expect_at(c, arst ? 0 : tgt, 1'b0, 1'b0);
                t_stop  = c;
                aborted = 1'b1;
                return;
            end
            if ((c - t0) % (n * P) == 0) begin
                if (tgt > d)      d = (d + s > tgt) ? tgt : d + s;
                else if (tgt < d) d = (d - s < tgt) ? tgt : d - s;
                if (d == tgt) begin
                    expect_at(c, d, 1'b0, 1'b1);
                    expect_at(c + 1, d, 1'b0, 1'b0);
                    t_stop = c;
                    return;
                end
                expect_at(c, d, 1'b1, 1'b0);
            end else if (tgt == d) begin
                expect_at(c, d, 1'b0, 1'b1);
                expect_at(c + 1, d, 1'b0, 1'b0);
                t_stop = c;
                return;
            end
        end
    endtask

    task automatic wait_drain(input int until_cyc);
        int lim;
        lim = until_cyc + 60;
        while ((cyc < until_cyc + 3 || q.size() != 0) && cyc < lim) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending events required 0", q.size());
            q.delete();
        end
    endtask

    // Called at a negedge where the ramp inputs were just applied; t0 is the entry edge.
    task automatic ramp_core(input int t0, input int tA, input int div, input int sz,
                             input int tchg_rel, input int tB, input int tabort_rel, input bit arst);
        int  n, s, tchg, tabort, t_stop;
        bit  ab, do_chg;
        n      = (div == 0) ? 1 : div;
        s      = (sz == 0) ? 1 : sz;
        tchg   = (tchg_rel > 0) ? t0 + tchg_rel : 0;
        tabort = (tabort_rel > 0) ? t0 + tabort_rel : 0;
        model_ramp(t0, tA, tchg, tB, tabort, arst, n, s, t_stop, ab);
        do_chg = (tchg > 0) && (tchg <= t_stop);
        while (cyc < t_stop) begin
            if (do_chg && cyc == tchg - 1) ctrl.target_duty = 8'(tB);
            if (ab && cyc == tabort - 1) begin
                if (arst) begin
                    #2;
                    rst_n = 1'b0;
                    ctrl.fade_en = 1'b0;
                    ctrl.target_duty = 8'h00;
                    #1;
                    check_val("async_rst_duty", int'(ctrl.duty_out), 0);
                    check_val("async_rst_busy", int'(ctrl.busy), 0);
                    check_val("async_rst_done", int'(ctrl.done), 0);
                    @(negedge clk);
                    #2 rst_n = 1'b1;
                end else begin
                    ctrl.fade_en = 1'b0;
                end
            end
            @(negedge clk);
        end
        wait_drain(t_stop);
    endtask

    task automatic run_ramp(input int tA, input int div, input int sz, input int tchg_rel,
                            input int tB, input int tabort_rel, input bit arst);
        @(negedge clk);
        ctrl.fade_en     = 1'b1;
        ctrl.target_duty = 8'(tA);
        ctrl.step_div    = 8'(div);
        ctrl.step_size   = 4'(sz);
        ramp_core(cyc + 1, tA, div, sz, tchg_rel, tB, tabort_rel, arst);
    endtask

    task automatic bypass(input int v);
        int c;
        @(negedge clk);
        ctrl.fade_en     = 1'b0;
        ctrl.target_duty = 8'(v);
        c = cyc + 1;
        expect_at(c, v, 1'b0, 1'b0);
        wait_drain(c);
    endtask

    initial begin
        int tA, dv, sz, tcr, tB, tar;
        bit ar;
        rst_n            = 1'b0;
        ctrl.fade_en     = 1'b1;
        ctrl.target_duty = 8'hAA;
        ctrl.step_div    = 8'd1;
        ctrl.step_size   = 4'd15;
        repeat (4) @(negedge clk);
        check_val("reset_duty", int'(ctrl.duty_out), 0);
        check_val("reset_busy", int'(ctrl.busy), 0);
        check_val("reset_done", int'(ctrl.done), 0);
        #2 rst_n = 1'b1;
        ramp_core(cyc + 1, 8'hAA, 1, 15, 0, 0, 0, 1'b0);

        bypass(8'h00);
        bypass(8'h80);

        bypass(8'h00);
        run_ramp(8'h10, 2, 4, 0, 0, 0, 1'b0);

        run_ramp(8'h03, 1, 4, 0, 0, 0, 1'b0);
        bypass(8'hF5);
        run_ramp(8'hFF, 1, 15, 0, 0, 0, 1'b0);

        bypass(8'h00);
        run_ramp(8'h40, 1, 8, 14, 8'h04, 0, 1'b0);
        bypass(8'h50);
        run_ramp(8'h53, 0, 0, 0, 0, 0, 1'b0);
        bypass(8'h00);
        run_ramp(8'h40, 1, 8, 10, 8'h10, 0, 1'b0);

        bypass(8'h00);
        run_ramp(8'h80, 1, 8, 0, 0, 18, 1'b0);
        bypass(8'h00);
        run_ramp(8'h80, 1, 8, 0, 0, 18, 1'b1);

        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                bypass(int'($urandom_range(0, 255)));
            end else begin
                tA  = int'($urandom_range(0, 255));
                dv  = int'($urandom_range(0, 3));
                sz  = int'($urandom_range(0, 15));
                tcr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : 0;
                tB  = int'($urandom_range(0, 255));
                tar = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 80)) : 0;
                ar  = 1'($urandom_range(0, 1));
                run_ramp(tA, dv, sz, tcr, tB, tar, ar);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        errors++;
        $display("FAIL timeout got running required finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
